simon_core_param: RTL



---
 rtl/simon_core_param.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/simon_core_param.sv
// Iterative SIMON 2N/MN block cipher core with an expanded round-key store.
// Define SIMON_UNROLL2_EN to run two rounds per cycle in RUN.
module simon_core_param #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 3,
    parameter int unsigned T = 42,
    parameter int unsigned J = 2
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  newKey,
    input  logic [M-1:0][N-1:0]   KEY,
    output logic                  loadKey,
    output logic                  doneKey,
    input  logic                  newData,
    input  logic                  enc_dec,
    input  logic [1:0][N-1:0]     blockIN,
    output logic                  loadData,
    output logic                  doneData,
    input  logic                  readData,
    output logic [1:0][N-1:0]     outData,
    output logic [2:0]            state
);

    localparam int unsigned IdxW = $clog2(T);

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] ZSel = (J == 0) ? Z0 : (J == 1) ? Z1 : (J == 2) ? Z2 :
                                   (J == 3) ? Z3 : Z4;

`ifdef SIMON_UNROLL2_EN
    localparam logic [IdxW-1:0] Step = IdxW'(2);
`else
    localparam logic [IdxW-1:0] Step = IdxW'(1);
`endif

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKeyExp = 3'd1,
        StReady  = 3'd2,
        StRun    = 3'd3,
        StDone   = 3'd4
    } state_e;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
        return (v >> s) | (v << (N - s));
    endfunction

    function automatic logic [N-1:0] rf(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    state_e              state_q, state_d;
    logic [N-1:0]        rk_q [T];
    logic [IdxW-1:0]     kidx_q, round_q;
    logic [5:0]          zidx_q;
    logic [N-1:0]        x_q, y_q;
    logic                dec_q;
    logic [1:0][N-1:0]   out_q;
    logic                done_key_q, done_data_q, rd_q;

    logic key_acc, data_acc, kexp_step, kexp_last, run_step, run_last, run_end;
    logic [N-1:0]    kx_tmp, kx_new;
    logic [5:0]      zpos;
    logic [IdxW-1:0] ki0;
    logic [N-1:0]    x1, y1, rnd_x, rnd_y;

`ifdef SIMON_UNROLL2_EN
    // Second round is skipped on the final cycle when T is odd.
    assign run_end = (round_q == IdxW'(T - 1)) || (round_q == IdxW'(T - 2));
`else
    assign run_end = (round_q == IdxW'(T - 1));
`endif

    always_comb begin
        state_d   = state_q;
        key_acc   = 1'b0;
        data_acc  = 1'b0;
        kexp_step = 1'b0;
        kexp_last = 1'b0;
        run_step  = 1'b0;
        run_last  = 1'b0;
        case (state_q)
            StIdle: begin
                if (newKey) begin
                    key_acc = 1'b1;
                    state_d = StKeyExp;
                end
            end
            StKeyExp: begin
                kexp_step = 1'b1;
                if (kidx_q == IdxW'(T - M - 1)) begin
                    kexp_last = 1'b1;
                    state_d   = StReady;
                end
            end
            StReady: begin
                if (newKey) begin
                    key_acc = 1'b1;
                    state_d = StKeyExp;
                end else if (newData && done_key_q) begin
                    data_acc = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                run_step = 1'b1;
                if (run_end) begin
                    run_last = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (newKey) begin
                    key_acc = 1'b1;
                    state_d = StKeyExp;
                end else if (readData && !rd_q) begin
                    state_d = StReady;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        zpos   = 6'd61 - zidx_q;
        kx_tmp = ror(rk_q[kidx_q + IdxW'(M - 1)], 3);
        if (M == 4) begin
            kx_tmp = kx_tmp ^ rk_q[kidx_q + IdxW'(1)];
        end
        kx_tmp = kx_tmp ^ ror(kx_tmp, 1);
        kx_new = ~rk_q[kidx_q] ^ kx_tmp ^ {{(N - 1){1'b0}}, ZSel[zpos]} ^ N'(3);
    end

    always_comb begin
        ki0   = dec_q ? (IdxW'(T - 1) - round_q) : round_q;
        x1    = y_q ^ rf(x_q) ^ rk_q[ki0];
        y1    = x_q;
        rnd_x = x1;
        rnd_y = y1;
`ifdef SIMON_UNROLL2_EN
        if (round_q != IdxW'(T - 1)) begin
            rnd_x = y1 ^ rf(x1) ^ rk_q[dec_q ? (IdxW'(T - 2) - round_q) : (round_q + IdxW'(1))];
            rnd_y = x1;
        end
`endif
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q     <= StIdle;
            kidx_q      <= '0;
            zidx_q      <= '0;
            round_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            dec_q       <= 1'b0;
            out_q       <= '0;
            done_key_q  <= 1'b0;
            done_data_q <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= readData;
            if (key_acc) begin
                kidx_q     <= '0;
                zidx_q     <= '0;
                done_key_q <= 1'b0;
            end else if (kexp_last) begin
                done_key_q <= 1'b1;
            end else if (kexp_step) begin
                kidx_q <= kidx_q + IdxW'(1);
                zidx_q <= (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
            end
            // Decrypt runs the encrypt round on swapped halves with reversed keys.
            if (data_acc) begin
                dec_q   <= ~enc_dec;
                x_q     <= enc_dec ? blockIN[1] : blockIN[0];
                y_q     <= enc_dec ? blockIN[0] : blockIN[1];
                round_q <= '0;
            end else if (run_step) begin
                x_q     <= rnd_x;
                y_q     <= rnd_y;
                round_q <= run_last ? '0 : round_q + Step;
            end
            if (run_last) begin
                done_data_q <= 1'b1;
                out_q       <= dec_q ? {rnd_y, rnd_x} : {rnd_x, rnd_y};
            end else if (state_q == StDone && state_d != StDone) begin
                done_data_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (key_acc) begin
            for (int i = 0; i < M; i++) begin
                rk_q[i] <= KEY[i];
            end
        end else if (kexp_step) begin
            rk_q[kidx_q + IdxW'(M)] <= kx_new;
        end
    end

    assign loadKey  = key_acc & ~R;
    assign loadData = data_acc & ~R;
    assign doneKey  = done_key_q;
    assign doneData = done_data_q;
    assign outData  = out_q;
    assign state    = state_q;

endmodule
